hazard_control_unit: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core.
- Detects load-use hazards that operand forwarding cannot cover, and flushes wrong-path instructions on taken branches/jumps.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with timeout detection.
- Drives every pipeline-register write enable and flush, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_control_unit.sv | 135 +++++++++++++
 tb/tb_hazard_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : 5-stage pipeline sequencer: load-use stalls, branch flushes,
//            memory-wait freeze with timeout, saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module hazard_control_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1Id,
    input  logic [4:0]       rs2Id,
    input  logic             usesRs2Id,
    input  logic [4:0]       rdEx,
    input  logic             memReadEx,
    input  logic             branchTakenEx,
    input  logic             memReqMem,
    input  logic             memReady,
    input  logic             clearErr,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExWrite,
    output logic             idExFlush,
    output logic             exMemWrite,
    output logic             memWbFlush,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic w_load_use;
    logic w_freeze;
    logic w_branch_flush;

    assign w_load_use = memReadEx && (rdEx != 5'd0) &&
                        ((rdEx == rs1Id) || (usesRs2Id && (rdEx == rs2Id)));

    // A MEM_WAIT cycle that sees memReady is already released.
    assign w_freeze = (r_state == ERROR) ||
                      ((r_state == MEM_WAIT) && !memReady) ||
                      ((r_state == RUN) && memReqMem && !memReady);

    assign w_branch_flush = rst_n && !w_freeze && branchTakenEx;

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExWrite  = 1'b1;
        idExFlush  = 1'b0;
        exMemWrite = 1'b1;
        memWbFlush = 1'b0;
        if (!rst_n) begin
            // Reset forces defaults regardless of pipeline inputs.
        end else if (w_freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (branchTakenEx) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (w_load_use) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            memTimeout <= 1'b0;
            stallCnt   <= '0;
            flushCnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (memReqMem && !memReady) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memReady) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state    <= ERROR;
                        memTimeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    if (clearErr) begin
                        r_state    <= RUN;
                        memTimeout <= 1'b0;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase

            if (!pcWrite && (stallCnt != c_CNT_MAX))
                stallCnt <= stallCnt + CNT_W'(1);
            if (w_branch_flush && (flushCnt != c_CNT_MAX))
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_control_unit
// Purpose  : Vector table plus hand sequences for hazard_control_unit.
// Revision : 1.0
// ============================================================================
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1Id, rs2Id, rdEx;
    logic       usesRs2Id, memReadEx, branchTakenEx, memReqMem, memReady, clearErr;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush;
    logic       memTimeout, memTimeout_s;
    logic [7:0] stallCnt, flushCnt;
    logic [1:0] stallCnt_s, flushCnt_s;
    logic       pw_s, ifw_s, iff_s, idw_s, idf_s, exw_s, mwf_s;

    int checks   = 0;
    int failures = 0;

    // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush}
    localparam logic [6:0] c_DEF = 7'b1101010;
    localparam logic [6:0] c_FRZ = 7'b0000001;
    localparam logic [6:0] c_BR  = 7'b1111110;
    localparam logic [6:0] c_LU  = 7'b0001110;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       uses2, mrd, br, req, rdy, clr;
        logic [6:0] exp;
    } vec_t;

    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_control_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rs1Id(rs1Id), .rs2Id(rs2Id), .usesRs2Id(usesRs2Id),
        .rdEx(rdEx), .memReadEx(memReadEx), .branchTakenEx(branchTakenEx),
        .memReqMem(memReqMem), .memReady(memReady), .clearErr(clearErr),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
        .memWbFlush(memWbFlush), .memTimeout(memTimeout),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    hazard_control_unit #(.TIMEOUT(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .rs1Id(rs1Id), .rs2Id(rs2Id), .usesRs2Id(usesRs2Id),
        .rdEx(rdEx), .memReadEx(memReadEx), .branchTakenEx(branchTakenEx),
        .memReqMem(memReqMem), .memReady(memReady), .clearErr(clearErr),
        .pcWrite(pw_s), .ifIdWrite(ifw_s), .ifIdFlush(iff_s),
        .idExWrite(idw_s), .idExFlush(idf_s), .exMemWrite(exw_s),
        .memWbFlush(mwf_s), .memTimeout(memTimeout_s),
        .stallCnt(stallCnt_s), .flushCnt(flushCnt_s)
    );

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic uses2, input logic mrd,
                                input logic br, input logic req, input logic rdy,
                                input logic clr, input logic [6:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.uses2 = uses2; v.mrd = mrd;
        v.br = br; v.req = req; v.rdy = rdy; v.clr = clr; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
    task automatic apply(input vec_t v, input string nm);
        logic [6:0] got, e;
        rs1Id = v.rs1; rs2Id = v.rs2; rdEx = v.rd; usesRs2Id = v.uses2;
        memReadEx = v.mrd; branchTakenEx = v.br; memReqMem = v.req;
        memReady = v.rdy; clearErr = v.clr;
        exp_q.push_back(v.exp);
        @(negedge clk);
        got = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: ctrl got %b expected %b", nm, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        rst_n = 1'b0;
        apply_idle();
        tbl[0] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, c_DEF);
        tbl[1] = mk(5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0, c_LU);
        tbl[2] = mk(5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0, 0, c_DEF);
        tbl[3] = mk(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, c_DEF);
        tbl[4] = mk(5'd3, 5'd7, 5'd7, 0, 1, 0, 0, 0, 0, c_DEF);
        tbl[5] = mk(5'd3, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0, c_LU);
        tbl[6] = mk(5'd9, 5'd0, 5'd9, 0, 1, 1, 0, 0, 0, c_BR);
        tbl[7] = mk(5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 0, c_BR);
        tbl[8] = mk(5'd1, 5'd2, 5'd3, 1, 0, 0, 1, 1, 0, c_DEF);
        tbl[9] = mk(5'd4, 5'd0, 5'd4, 0, 1, 0, 1, 1, 0, c_LU);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", int'({pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
                                exMemWrite, memWbFlush}), int'(c_DEF));
        chk("reset_stall", int'(stallCnt), 0);
        chk("reset_flush", int'(flushCnt), 0);
        chk("reset_tmo", int'(memTimeout), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
            if (i == 2) chk("lu_stall_cnt", int'(stallCnt), 1);
        end
        chk("table_stall_cnt", int'(stallCnt), 3);
        chk("table_flush_cnt", int'(flushCnt), 2);

        // Memory wait: three frozen cycles, release on the ready cycle.
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, c_FRZ), "wait_c0");
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, c_FRZ), "wait_c1_br_ignored");
        apply(mk(5'd6, 5'd0, 5'd6, 0, 1, 0, 1, 0, 0, c_FRZ), "wait_c2_lu_ignored");
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, c_DEF), "wait_release");
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, c_DEF), "wait_after");
        chk("wait_stall_cnt", int'(stallCnt), 6);
        chk("wait_flush_cnt", int'(flushCnt), 2);
        chk("wait_tmo", int'(memTimeout), 0);

        // Timeout at TIMEOUT=4, then clearErr.
        for (int i = 0; i < 4; i++) begin
            apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, c_FRZ), $sformatf("tmo_c%0d", i));
            if (i == 2) chk("tmo_not_yet", int'(memTimeout), 0);
        end
        chk("tmo_set", int'(memTimeout), 1);
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0, c_FRZ), "err_frozen0");
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, c_FRZ), "err_frozen1");
        chk("tmo_sticky", int'(memTimeout), 1);
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, c_FRZ), "err_clear_cycle");
        chk("tmo_cleared", int'(memTimeout), 0);
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, c_DEF), "err_run");
        chk("tmo_stall_cnt", int'(stallCnt), 13);

        // Reset asserted in the middle of a memory wait.
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, c_FRZ), "rw_c0");
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, c_FRZ), "rw_c1");
        #2 rst_n = 1'b0;
        #1;
        chk("rw_ctrl", int'({pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
                             exMemWrite, memWbFlush}), int'(c_DEF));
        chk("rw_stall", int'(stallCnt), 0);
        chk("rw_flush", int'(flushCnt), 0);
        chk("rw_tmo", int'(memTimeout), 0);
        apply_idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, c_DEF), "rw_run");

        // Saturation of a 2-bit stall counter.
        for (int i = 0; i < 5; i++)
            apply(mk(5'd8, 5'd0, 5'd8, 0, 1, 0, 0, 0, 0, c_LU), $sformatf("sat%0d", i));
        chk("sat_small", int'(stallCnt_s), 3);
        chk("sat_wide", int'(stallCnt), 5);
        apply(mk(5'd8, 5'd0, 5'd8, 0, 1, 0, 0, 0, 0, c_LU), "sat5");
        chk("sat_small_held", int'(stallCnt_s), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic apply_idle();
        rs1Id = '0; rs2Id = '0; rdEx = '0; usesRs2Id = 1'b0; memReadEx = 1'b0;
        branchTakenEx = 1'b0; memReqMem = 1'b0; memReady = 1'b0; clearErr = 1'b0;
    endtask

endmodule
`default_nettype wire
